ifu_refill_ctrl: RTL and testbench
==================================

// Module: ifu_refill_ctrl
// PURPOSE
//  Miss/refill controller directly downstream of the IFU instruction cache.
//  Takes the cache's level-held miss request (tag + valid), issues one line read on a narrow memory bus,
//  assembles MEM_DATA_WIDTH beats into a full line, and returns tag + line to the cache as a one-cycle valid pulse.
//  One outstanding refill at a time. A stall watchdog aborts refills that stop receiving data.
// PARAMETERS
//  ADDR_WIDTH      32   byte address width of the memory bus
//  TAG_WIDTH       28   line tag width; ADDR_WIDTH = TAG_WIDTH + OFFSET_WIDTH
//  OFFSET_WIDTH    4    byte-offset bits within a line
//  LINE_WIDTH      128  cache line width in bits
//  MEM_DATA_WIDTH  32   memory read beat width; NUM_BEATS = LINE_WIDTH/MEM_DATA_WIDTH (exact divisor)
//  STALL_LIMIT     255  max consecutive beat-less cycles in FILL before abort
// PORTS
//  Clock            in   1               clock
//  Rst              in   1               reset, asynchronous, active-high
//  cache_reqTagIn   in   TAG_WIDTH       missing tag (cache mem_reqTagOut)
//  cache_reqValidIn in   1               miss pending, level (cache mem_reqTagValidOut)
//  cache_rspTagOut  out  TAG_WIDTH       tag of returned line
//  cache_rspLineOut out  LINE_WIDTH      returned line
//  cache_rspValidOut out 1               1-cycle pulse: tag/line valid
//  mem_reqValidOut  out  1               memory read request valid
//  mem_reqReadyIn   in   1               memory accepts request
//  mem_reqAddrOut   out  ADDR_WIDTH      line base address {tag, OFFSET_WIDTH'0}
//  mem_rdValidIn    in   1               read beat valid
//  mem_rdDataIn     in   MEM_DATA_WIDTH  read beat data
//  busyOut          out  1               state != IDLE
//  stallErrOut      out  1               1-cycle pulse: refill aborted by watchdog
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs, line buffer, beat and stall counters = 0.
//    Reset mid-refill discards the transaction; the memory model is reset alongside.
//  - FSM IDLE -> REQ -> FILL -> RESP -> COOL -> IDLE. All outputs registered.
//  - IDLE: if cache_reqValidIn=1, latch cache_reqTagIn into tag_q, go REQ.
//  - REQ: mem_reqValidOut=1, mem_reqAddrOut={tag_q,0}, both held stable until mem_reqReadyIn=1;
//    on valid&ready go FILL with beat_cnt=0, stall_cnt=0.
//  - FILL: each mem_rdValidIn=1 writes beat k to line[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH], k=beat_cnt,
//    increments beat_cnt, clears stall_cnt. Beat 0 is the lowest address.
//    Beat NUM_BEATS-1 accepted -> go RESP.
//  - Cycles with no beat increment stall_cnt (saturating). stall_cnt reaching STALL_LIMIT -> stallErrOut=1 for 1 cycle,
//    go IDLE, no response. Late beats of an aborted refill are ignored by IDLE/REQ.
//  - RESP: cache_rspValidOut=1 for exactly 1 cycle; cache_rspTagOut=tag_q, cache_rspLineOut=assembled line.
//    Tag/line outputs hold their value until the next RESP.
//  - COOL: 1 cycle; cache_reqValidIn ignored (the cache tag array updates on the RESP edge, so the request drops).
//    Prevents duplicate refill of the same line.
//  - Request changes or drops mid-refill (redirect): the refill completes with the original tag_q.
//    The cache discards it on tag mismatch. A new request is taken only in IDLE.
//  - mem_rdValidIn outside FILL: ignored, no state change.
//  - Latency: req in IDLE at cycle 0 -> mem_reqValidOut cycle 1. With ready at cycle 1 and beats at cycles 2..(1+NUM_BEATS),
//    cache_rspValidOut is at cycle 2+NUM_BEATS (6 with defaults).
//  - busyOut=1 in REQ, FILL, RESP, COOL.
// TESTING
//  1 Basic: tag=0x0000123 valid; ready same cycle; beats 0xA0,0xA1,0xA2,0xA3 back-to-back.
//    -> addr 0x00001230; rspValid at cycle 6; line=0x000000A3_000000A2_000000A1_000000A0.
//  2 Backpressure: mem_reqReadyIn low for 5 cycles -> mem_reqValidOut and addr stable all 5 cycles; 1 request accepted.
//  3 Gapped beats: 3 idle cycles between each beat -> correct line; rspValid 1 cycle after 4th beat; no stallErrOut.
//  4 Watchdog: 2 beats then silence -> stallErrOut pulse after 255 idle cycles; no rspValid; busyOut=0 next cycle.
//  5 Redirect: tag changes 0x123->0x456 during FILL -> response tag 0x123; then a second refill for 0x456.
//    reqValid held through COOL -> no duplicate request.
//  6 Async reset in FILL after 2 beats -> outputs 0 immediately; next refill returns a clean line, no stale beats.

Source files
------------

// File: rtl/ifu_refill_ctrl.sv
// Cache-line refill controller: one outstanding line read, beats assembled into a line, returned to the cache.
// Latency: miss seen in IDLE -> memory request next cycle; response one cycle after the last beat.
// Backpressure: request held stable until mem_reqReadyIn; no beat backpressure, watchdog aborts a stalled fill.
module ifu_refill_ctrl #(
   parameter int ADDR_WIDTH     = 32,
   parameter int TAG_WIDTH      = 28,
   parameter int OFFSET_WIDTH   = 4,
   parameter int LINE_WIDTH     = 128,
   parameter int MEM_DATA_WIDTH = 32,
   parameter int STALL_LIMIT    = 255
) (
   input  logic                      Clock,
   input  logic                      Rst,
   input  logic [TAG_WIDTH-1:0]      cache_reqTagIn,
   input  logic                      cache_reqValidIn,
   output logic [TAG_WIDTH-1:0]      cache_rspTagOut,
   output logic [LINE_WIDTH-1:0]     cache_rspLineOut,
   output logic                      cache_rspValidOut,
   output logic                      mem_reqValidOut,
   input  logic                      mem_reqReadyIn,
   output logic [ADDR_WIDTH-1:0]     mem_reqAddrOut,
   input  logic                      mem_rdValidIn,
   input  logic [MEM_DATA_WIDTH-1:0] mem_rdDataIn,
   output logic                      busyOut,
   output logic                      stallErrOut
);

   localparam int NUM_BEATS = LINE_WIDTH / MEM_DATA_WIDTH;
   localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam int STALL_W   = $clog2(STALL_LIMIT + 1);
   localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

   typedef enum logic [2:0] {IDLE, REQ, FILL, RESP, COOL} state_t;

   state_t                  state, stateNext;
   logic [TAG_WIDTH-1:0]    tagQ, tagNext;
   logic [BEAT_W-1:0]       beatCnt, beatNext;
   logic [STALL_W-1:0]      stallCnt, stallNext;
   logic [LINE_WIDTH-1:0]   lineQ, lineNext;
   logic                    stallAbort;

   // Next-state, line assembly and watchdog decisions.
   always_comb begin
      stateNext  = state;
      tagNext    = tagQ;
      beatNext   = beatCnt;
      stallNext  = stallCnt;
      lineNext   = lineQ;
      stallAbort = 1'b0;
      case (state)
         IDLE: begin
            if (cache_reqValidIn) begin
               tagNext   = cache_reqTagIn;
               stateNext = REQ;
            end
         end
         REQ: begin
            // mem_reqValidOut is high throughout REQ, so ready alone completes the handshake.
            if (mem_reqReadyIn) begin
               beatNext  = '0;
               stallNext = '0;
               stateNext = FILL;
            end
         end
         FILL: begin
            if (mem_rdValidIn) begin
               lineNext[beatCnt*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_rdDataIn;
               beatNext  = beatCnt + 1'b1;
               stallNext = '0;
               if (beatCnt == LAST_BEAT) begin
                  stateNext = RESP;
               end
            end else begin
               if (stallCnt != STALL_MAX) begin
                  stallNext = stallCnt + 1'b1;
               end
               if (stallNext == STALL_MAX) begin
                  stallAbort = 1'b1;
                  stateNext  = IDLE;
               end
            end
         end
         RESP: stateNext = COOL;
         // The cache's request is still up for one cycle after RESP; ignore it here.
         COOL: stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // State, latched tag, counters and line buffer.
   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         state    <= IDLE;
         tagQ     <= '0;
         beatCnt  <= '0;
         stallCnt <= '0;
         lineQ    <= '0;
      end else begin
         state    <= stateNext;
         tagQ     <= tagNext;
         beatCnt  <= beatNext;
         stallCnt <= stallNext;
         lineQ    <= lineNext;
      end
   end

   // Registered outputs, decoded from the state being entered.
   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         mem_reqValidOut   <= 1'b0;
         mem_reqAddrOut    <= '0;
         cache_rspValidOut <= 1'b0;
         cache_rspTagOut   <= '0;
         cache_rspLineOut  <= '0;
         busyOut           <= 1'b0;
         stallErrOut       <= 1'b0;
      end else begin
         mem_reqValidOut   <= (stateNext == REQ);
         mem_reqAddrOut    <= {tagNext, {OFFSET_WIDTH{1'b0}}};
         cache_rspValidOut <= (stateNext == RESP);
         busyOut           <= (stateNext != IDLE);
         stallErrOut       <= stallAbort;
         if (stateNext == RESP) begin
            cache_rspTagOut  <= tagQ;
            cache_rspLineOut <= lineNext;
         end
      end
   end

endmodule

// File: tb/tb_ifu_refill_ctrl.sv
// Bench for ifu_refill_ctrl: randomized refills against a transaction-level model of line assembly and timing.
module tb_ifu_refill_ctrl;

   localparam int TW = 28;
   localparam int AW = 32;
   localparam int LW = 128;
   localparam int DW = 32;

   logic          Clock;
   logic          Rst;
   logic [TW-1:0] cache_reqTagIn;
   logic          cache_reqValidIn;
   logic [TW-1:0] cache_rspTagOut;
   logic [LW-1:0] cache_rspLineOut;
   logic          cache_rspValidOut;
   logic          mem_reqValidOut;
   logic          mem_reqReadyIn;
   logic [AW-1:0] mem_reqAddrOut;
   logic          mem_rdValidIn;
   logic [DW-1:0] mem_rdDataIn;
   logic          busyOut;
   logic          stallErrOut;

   ifu_refill_ctrl dut (
      .Clock(Clock), .Rst(Rst),
      .cache_reqTagIn(cache_reqTagIn), .cache_reqValidIn(cache_reqValidIn),
      .cache_rspTagOut(cache_rspTagOut), .cache_rspLineOut(cache_rspLineOut),
      .cache_rspValidOut(cache_rspValidOut),
      .mem_reqValidOut(mem_reqValidOut), .mem_reqReadyIn(mem_reqReadyIn),
      .mem_reqAddrOut(mem_reqAddrOut),
      .mem_rdValidIn(mem_rdValidIn), .mem_rdDataIn(mem_rdDataIn),
      .busyOut(busyOut), .stallErrOut(stallErrOut)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   always @(posedge Clock) cyc <= cyc + 1;

   typedef struct {int c; logic [TW-1:0] tag; logic [LW-1:0] line;} rsp_t;
   typedef struct {int c; logic [AW-1:0] addr;} req_t;
   rsp_t rspQ[$];
   req_t reqQ[$];
   int   stallQ[$];
   int   holdViol = 0;
   int   reqValidCycles = 0;
   logic prevPending = 1'b0;
   logic [AW-1:0] prevAddr = '0;

   // Event recorder: logs handshakes, responses and aborts with their cycle numbers.
   always @(negedge Clock) begin
      if (Rst) begin
         prevPending = 1'b0;
      end else begin
         if (prevPending && (!mem_reqValidOut || mem_reqAddrOut !== prevAddr)) holdViol++;
         if (mem_reqValidOut) reqValidCycles++;
         if (mem_reqValidOut && mem_reqReadyIn) reqQ.push_back('{cyc, mem_reqAddrOut});
         if (cache_rspValidOut) rspQ.push_back('{cyc, cache_rspTagOut, cache_rspLineOut});
         if (stallErrOut) stallQ.push_back(cyc);
         prevPending = mem_reqValidOut && !mem_reqReadyIn;
         prevAddr    = mem_reqAddrOut;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic clear_log();
      rspQ.delete();
      reqQ.delete();
      stallQ.delete();
      holdViol = 0;
      reqValidCycles = 0;
   endtask

   // Memory/cache stimulus for one refill; leaves the request up and returns in the expected RESP cycle.
   task automatic drive_refill(input logic [TW-1:0] tag, input int bp, input int minGap, input int maxGap,
                               input int nBeats, input bit junk, input bit fixedData,
                               input bit redirect, input logic [TW-1:0] newTag,
                               output logic [LW-1:0] expLine, output int startCyc, output int lastCyc);
      logic [DW-1:0] d;
      startCyc = cyc;
      lastCyc  = cyc;
      expLine  = '0;
      cache_reqValidIn = 1'b1;
      cache_reqTagIn   = tag;
      if (junk) begin
         mem_rdValidIn = 1'($urandom_range(0, 1));
         mem_rdDataIn  = $urandom;
      end
      tick();
      for (int i = 0; i <= bp; i++) begin
         mem_reqReadyIn = (i == bp);
         if (junk) begin
            mem_rdValidIn = 1'($urandom_range(0, 1));
            mem_rdDataIn  = $urandom;
         end
         tick();
      end
      mem_reqReadyIn = 1'b0;
      mem_rdValidIn  = 1'b0;
      for (int k = 0; k < nBeats; k++) begin
         if (k > 0) repeat ($urandom_range(maxGap, minGap)) tick();
         d = fixedData ? DW'(32'hA0 + k) : DW'($urandom);
         mem_rdValidIn = 1'b1;
         mem_rdDataIn  = d;
         expLine[k*DW +: DW] = d;
         lastCyc = cyc;
         if (redirect && k == 1) cache_reqTagIn = newTag;
         tick();
         mem_rdValidIn = 1'b0;
      end
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      cache_reqValidIn = 1'b0;
      cache_reqTagIn   = '0;
      mem_reqReadyIn   = 1'b0;
      mem_rdValidIn    = 1'b0;
      mem_rdDataIn     = '0;
      #2;
      vectors++; if (busyOut !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busyOut); end
      vectors++; if (mem_reqValidOut !== 1'b0) begin miscompares++; $display("FAIL reset_reqvalid: got %0b want 0", mem_reqValidOut); end
      vectors++; if (mem_reqAddrOut !== '0) begin miscompares++; $display("FAIL reset_addr: got %0h want 0", mem_reqAddrOut); end
      vectors++; if (cache_rspValidOut !== 1'b0 || stallErrOut !== 1'b0) begin miscompares++; $display("FAIL reset_pulses: got rsp=%0b err=%0b want 0", cache_rspValidOut, stallErrOut); end
      vectors++; if (cache_rspTagOut !== '0 || cache_rspLineOut !== '0) begin miscompares++; $display("FAIL reset_rspdata: got tag=%0h line=%0h want 0", cache_rspTagOut, cache_rspLineOut); end
      tick(); tick();
      Rst = 1'b0;
      tick();
      vectors++; if (busyOut !== 1'b0 || mem_reqValidOut !== 1'b0) begin miscompares++; $display("FAIL reset_idle: got busy=%0b req=%0b want 0", busyOut, mem_reqValidOut); end
   endtask

   task automatic test_basic();
      logic [LW-1:0] el;
      int s, l;
      clear_log();
      drive_refill(28'h0000123, 0, 0, 0, 4, 1'b0, 1'b1, 1'b0, '0, el, s, l);
      vectors++; if (busyOut !== 1'b1) begin miscompares++; $display("FAIL basic_busy_resp: got %0b want 1", busyOut); end
      cache_reqValidIn = 1'b0;
      repeat (3) tick();
      vectors++; if (reqQ.size() != 1) begin miscompares++; $display("FAIL basic_reqcount: got %0d want 1", reqQ.size()); end
      else begin
         vectors++; if (reqQ[0].addr !== 32'h00001230) begin miscompares++; $display("FAIL basic_addr: got %0h want 00001230", reqQ[0].addr); end
         vectors++; if (reqQ[0].c != s + 1) begin miscompares++; $display("FAIL basic_reqcyc: got %0d want %0d", reqQ[0].c - s, 1); end
      end
      vectors++; if (rspQ.size() != 1) begin miscompares++; $display("FAIL basic_rspcount: got %0d want 1", rspQ.size()); end
      else begin
         vectors++; if (rspQ[0].c != s + 6) begin miscompares++; $display("FAIL basic_latency: got %0d want 6", rspQ[0].c - s); end
         vectors++; if (rspQ[0].tag !== 28'h0000123) begin miscompares++; $display("FAIL basic_tag: got %0h want 123", rspQ[0].tag); end
         vectors++; if (rspQ[0].line !== 128'h000000A3_000000A2_000000A1_000000A0) begin miscompares++; $display("FAIL basic_line: got %0h want 000000a3000000a2000000a1000000a0", rspQ[0].line); end
      end
      vectors++; if (busyOut !== 1'b0) begin miscompares++; $display("FAIL basic_idle: got busy=%0b want 0", busyOut); end
   endtask

   task automatic test_backpressure();
      logic [LW-1:0] el;
      int s, l;
      clear_log();
      drive_refill(28'h0ABCDEF, 5, 0, 1, 4, 1'b0, 1'b0, 1'b0, '0, el, s, l);
      cache_reqValidIn = 1'b0;
      repeat (3) tick();
      vectors++; if (holdViol != 0) begin miscompares++; $display("FAIL bp_stable: got %0d unstable cycles want 0", holdViol); end
      vectors++; if (reqValidCycles != 6) begin miscompares++; $display("FAIL bp_validcycles: got %0d want 6", reqValidCycles); end
      vectors++; if (reqQ.size() != 1) begin miscompares++; $display("FAIL bp_reqcount: got %0d want 1", reqQ.size()); end
      else begin
         vectors++; if (reqQ[0].c != s + 6 || reqQ[0].addr !== {28'h0ABCDEF, 4'h0}) begin miscompares++; $display("FAIL bp_accept: got cyc+%0d addr=%0h want cyc+6 addr=%0h", reqQ[0].c - s, reqQ[0].addr, {28'h0ABCDEF, 4'h0}); end
      end
      vectors++; if (rspQ.size() != 1 || rspQ[0].line !== el || rspQ[0].c != l + 1) begin miscompares++; $display("FAIL bp_rsp: got %0d responses want 1 with line=%0h at last beat+1", rspQ.size(), el); end
   endtask

   task automatic test_gapped();
      logic [LW-1:0] el;
      int s, l;
      clear_log();
      drive_refill(28'h7654321, 0, 3, 3, 4, 1'b0, 1'b0, 1'b0, '0, el, s, l);
      cache_reqValidIn = 1'b0;
      repeat (3) tick();
      vectors++; if (rspQ.size() != 1) begin miscompares++; $display("FAIL gap_rspcount: got %0d want 1", rspQ.size()); end
      else begin
         vectors++; if (rspQ[0].c != l + 1) begin miscompares++; $display("FAIL gap_latency: got %0d want 1 after last beat", rspQ[0].c - l); end
         vectors++; if (rspQ[0].line !== el) begin miscompares++; $display("FAIL gap_line: got %0h want %0h", rspQ[0].line, el); end
      end
      vectors++; if (stallQ.size() != 0) begin miscompares++; $display("FAIL gap_stallerr: got %0d pulses want 0", stallQ.size()); end
   endtask

   task automatic test_watchdog();
      logic [LW-1:0] el;
      int s, l;
      clear_log();
      drive_refill(28'h0000BAD, 0, 0, 0, 2, 1'b0, 1'b0, 1'b0, '0, el, s, l);
      cache_reqValidIn = 1'b0;
      while (stallQ.size() == 0 && cyc < l + 300) tick();
      vectors++; if (stallQ.size() != 1) begin miscompares++; $display("FAIL wd_pulsecount: got %0d want 1", stallQ.size()); end
      else begin
         vectors++; if (stallQ[0] != l + 256) begin miscompares++; $display("FAIL wd_timing: got %0d idle cycles want 255", stallQ[0] - l - 1); end
      end
      vectors++; if (busyOut !== 1'b0) begin miscompares++; $display("FAIL wd_busy: got %0b want 0", busyOut); end
      // Late beats from the aborted read arrive in IDLE.
      repeat (3) begin
         mem_rdValidIn = 1'b1;
         mem_rdDataIn  = $urandom;
         tick();
      end
      mem_rdValidIn = 1'b0;
      tick();
      vectors++; if (busyOut !== 1'b0 || rspQ.size() != 0 || stallQ.size() != 1) begin miscompares++; $display("FAIL wd_after: got busy=%0b rsp=%0d err=%0d want 0/0/1", busyOut, rspQ.size(), stallQ.size()); end
   endtask

   task automatic test_redirect();
      logic [LW-1:0] el1, el2;
      int s1, l1, s2, l2;
      clear_log();
      drive_refill(28'h0000123, 1, 0, 2, 4, 1'b0, 1'b0, 1'b1, 28'h0000456, el1, s1, l1);
      tick(); tick();
      drive_refill(28'h0000456, 0, 0, 2, 4, 1'b0, 1'b0, 1'b0, '0, el2, s2, l2);
      tick();
      cache_reqValidIn = 1'b0;
      repeat (4) tick();
      vectors++; if (reqQ.size() != 2) begin miscompares++; $display("FAIL redir_reqcount: got %0d want 2", reqQ.size()); end
      vectors++; if (rspQ.size() != 2) begin miscompares++; $display("FAIL redir_rspcount: got %0d want 2", rspQ.size()); end
      if (reqQ.size() == 2 && rspQ.size() == 2) begin
         vectors++; if (rspQ[0].tag !== 28'h0000123 || rspQ[0].line !== el1) begin miscompares++; $display("FAIL redir_first: got tag=%0h want 123", rspQ[0].tag); end
         vectors++; if (rspQ[1].tag !== 28'h0000456 || rspQ[1].line !== el2) begin miscompares++; $display("FAIL redir_second: got tag=%0h want 456", rspQ[1].tag); end
         vectors++; if (reqQ[1].addr !== 32'h00004560 || reqQ[1].c != rspQ[0].c + 3) begin miscompares++; $display("FAIL redir_cool: got addr=%0h at rsp+%0d want 4560 at rsp+3", reqQ[1].addr, reqQ[1].c - rspQ[0].c); end
      end
   endtask

   task automatic test_async_reset();
      logic [LW-1:0] el;
      int s, l;
      clear_log();
      drive_refill(28'h0000ACE, 0, 0, 0, 2, 1'b0, 1'b0, 1'b0, '0, el, s, l);
      #2;
      Rst = 1'b1;
      cache_reqValidIn = 1'b0;
      #1;
      vectors++; if (busyOut !== 1'b0 || mem_reqValidOut !== 1'b0 || mem_reqAddrOut !== '0) begin miscompares++; $display("FAIL arst_ctrl: got busy=%0b req=%0b addr=%0h want 0", busyOut, mem_reqValidOut, mem_reqAddrOut); end
      vectors++; if (cache_rspLineOut !== '0 || cache_rspTagOut !== '0 || cache_rspValidOut !== 1'b0) begin miscompares++; $display("FAIL arst_rsp: got tag=%0h line=%0h want 0", cache_rspTagOut, cache_rspLineOut); end
      tick();
      Rst = 1'b0;
      tick();
      clear_log();
      drive_refill(28'h0000BEE, 0, 0, 1, 4, 1'b0, 1'b0, 1'b0, '0, el, s, l);
      cache_reqValidIn = 1'b0;
      repeat (3) tick();
      vectors++; if (rspQ.size() != 1 || rspQ[0].line !== el || rspQ[0].tag !== 28'h0000BEE || rspQ[0].c != l + 1) begin miscompares++; $display("FAIL arst_clean: got %0d responses want 1 with tag=bee line=%0h", rspQ.size(), el); end
   endtask

   task automatic test_random();
      logic [LW-1:0] el;
      logic [TW-1:0] tag;
      int s, l, bp;
      for (int n = 0; n < 25; n++) begin
         clear_log();
         tag = TW'($urandom);
         bp  = $urandom_range(0, 3);
         drive_refill(tag, bp, 0, 3, 4, 1'b1, 1'b0, 1'b0, '0, el, s, l);
         cache_reqValidIn = 1'b0;
         repeat ($urandom_range(2, 4)) tick();
         vectors++;
         if (reqQ.size() != 1 || reqQ[0].addr !== {tag, 4'h0} || reqQ[0].c != s + 1 + bp) begin
            miscompares++; $display("FAIL rand_req[%0d]: got %0d requests want 1 at addr %0h", n, reqQ.size(), {tag, 4'h0});
         end
         vectors++;
         if (rspQ.size() != 1 || rspQ[0].c != l + 1 || rspQ[0].tag !== tag || rspQ[0].line !== el) begin
            miscompares++; $display("FAIL rand_rsp[%0d]: got %0d responses want 1 tag=%0h line=%0h", n, rspQ.size(), tag, el);
         end
         vectors++;
         if (stallQ.size() != 0 || holdViol != 0) begin
            miscompares++; $display("FAIL rand_misc[%0d]: got err=%0d unstable=%0d want 0/0", n, stallQ.size(), holdViol);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_gapped();
      test_watchdog();
      test_redirect();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
